// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave oversampled in the clk domain: R/W + address header, then burst data words.
// Pin edges act on the 3rd clk edge after they occur; every output comes straight from a flop.
module spi_reg_slave #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int NUM_REGS = 4,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       cs,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       addr_err,
  output logic                       busy
);
  localparam int PW    = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int CNT_W = $clog2(PW + 1);
  localparam int RW    = NUM_REGS * DATA_W;

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t            state_q, state_d;
  logic [2:0]        sclk_sync_q, sclk_sync_d;
  logic [1:0]        cs_sync_q, cs_sync_d;
  logic [1:0]        mosi_sync_q, mosi_sync_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]     shift_q, shift_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [RW-1:0]     regs_d;
  logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic              wr_strobe_q, wr_strobe_d, addr_err_q, addr_err_d;
  logic              busy_q, busy_d, wait_cs_q, wait_cs_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, word;
  logic [ADDR_W:0]   hdr;
  logic              sclk_rise, sclk_fall, cs_hi, mosi_s;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W + 1)'(NUM_REGS);
  endfunction

  // Unimplemented addresses read as zero.
  function automatic logic [DATA_W-1:0] rd_reg(input logic [RW-1:0] r, input logic [ADDR_W-1:0] a);
    rd_reg = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_W'(i)) rd_reg = r[i*DATA_W +: DATA_W];
  endfunction

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_hi     = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign word      = {shift_q[DATA_W-2:0], mosi_s};
  assign hdr       = {shift_q[ADDR_W-1:0], mosi_s};
  assign addr_nxt  = addr_q + ADDR_W'(1);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[0], cs};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    tx_shift_d  = tx_shift_q;
    regs_d      = regs_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    wr_strobe_d = 1'b0;
    addr_err_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    // After reset, a frame already under way must end (cs high) before a new one is accepted.
    wait_cs_d   = wait_cs_q & ~cs_hi;
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (!cs_hi && !wait_cs_q) begin
          state_d   = HDR;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      HDR: begin
        if (cs_hi) begin
          state_d = IDLE;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[PW-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(ADDR_W)) begin
            rw_d      = hdr[ADDR_W];
            addr_d    = hdr[ADDR_W-1:0];
            bit_cnt_d = '0;
            state_d   = DATA;
            if (hdr[ADDR_W]) tx_shift_d = rd_reg(regs_q, hdr[ADDR_W-1:0]);
          end
        end
      end
      DATA: begin
        if (cs_hi) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sclk_fall && rw_q) begin
          miso_d     = tx_shift_q[DATA_W-1];
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          miso_oe_d  = 1'b1;
        end else if (sclk_rise) begin
          shift_d   = {shift_q[PW-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            addr_d    = addr_nxt;
            if (!in_range(addr_q)) begin
              addr_err_d = 1'b1;
            end else if (!rw_q) begin
              for (int i = 0; i < NUM_REGS; i++)
                if (addr_q == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = word;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = word;
            end
            if (rw_q) tx_shift_d = rd_reg(regs_q, addr_nxt);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      tx_shift_q  <= '0;
      regs_q      <= RST_VAL;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      addr_err_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      wait_cs_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      tx_shift_q  <= tx_shift_d;
      regs_q      <= regs_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      wr_strobe_q <= wr_strobe_d;
      addr_err_q  <= addr_err_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      wait_cs_q   <= wait_cs_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign addr_err  = addr_err_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: a default instance plus a 2-bit-address instance sharing sclk/mosi/rst.
// Expected writes, errors and read words are queued when driven and checked when the DUT responds.
module tb_spi_reg_slave;
  localparam int HALF = 5;
  localparam logic [63:0] RST1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

  logic clk = 1'b0;
  logic rst, sclk, cs0, cs1, mosi;
  logic miso0, oe0, ws0, ae0, busy0;
  logic [63:0] regs0;
  logic [7:0] wa0;
  logic [15:0] wd0;
  logic miso1, oe1, ws1, ae1, busy1;
  logic [63:0] regs1;
  logic [1:0] wa1;
  logic [15:0] wd1;

  int n_tests = 0;
  int n_fail = 0;
  logic [23:0] exp_wr_q[$];
  int exp_err_q[$];
  logic [63:0] exp_rd_q[$];
  logic [63:0] model;
  logic [63:0] rx;
  logic [23:0] e_wr;

  always #5 clk = ~clk;

  spi_reg_slave u_dut0 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs0), .mosi(mosi),
    .miso(miso0), .miso_oe(oe0), .regs_q(regs0), .wr_strobe(ws0),
    .wr_addr(wa0), .wr_data(wd0), .addr_err(ae0), .busy(busy0)
  );

  spi_reg_slave #(.ADDR_W(2), .DATA_W(16), .NUM_REGS(4), .RST_VAL(RST1)) u_dut1 (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs1), .mosi(mosi),
    .miso(miso1), .miso_oe(oe1), .regs_q(regs1), .wr_strobe(ws1),
    .wr_addr(wa1), .wr_data(wd1), .addr_err(ae1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ws0) begin
      check("wr_pending", 64'(exp_wr_q.size() > 0), 64'd1);
      if (exp_wr_q.size() > 0) begin
        e_wr = exp_wr_q.pop_front();
        check("wr_addr", 64'(wa0), 64'(e_wr[23:16]));
        check("wr_data", 64'(wd0), 64'(e_wr[15:0]));
        check("wr_regs", 64'(regs0[e_wr[23:16]*16 +: 16]), 64'(e_wr[15:0]));
      end
    end
    if (ae0) begin
      check("err_pending", 64'(exp_err_q.size() > 0), 64'd1);
      if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
    end
    if (ws1 || ae1) check("dut1_strobe_err", 64'({ws1, ae1}), 64'd0);
  end

  task automatic cs_on(input bit sel);
    if (sel) cs1 = 1'b0;
    else cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_off();
    repeat (HALF) @(negedge clk);
    cs0 = 1'b1;
    cs1 = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Master side: drive mosi, raise sclk, sample miso/miso_oe at the rise, then drop sclk.
  task automatic spi_bits(input bit sel, input int n, input logic [63:0] tx, input logic exp_oe,
                          input string tag, output logic [63:0] rx_o);
    rx_o = '0;
    for (int i = n - 1; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      rx_o[i] = sel ? miso1 : miso0;
      check(tag, 64'(sel ? oe1 : oe0), 64'(exp_oe));
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [15:0] d);
    exp_wr_q.push_back({a, d});
    model[a*16 +: 16] = d;
    cs_on(0);
    check("busy_in_frame", 64'(busy0), 64'd1);
    spi_bits(0, 25, 64'({1'b0, a, d}), 1'b0, "oe_wr", rx);
    cs_off();
  endtask

  task automatic rd_frame(input bit sel, input int aw, input logic [7:0] a, input int nw,
                          input logic [63:0] exp, input string tag);
    logic [63:0] hdr;
    hdr = (64'd1 << aw) | 64'(a);
    exp_rd_q.push_back(exp);
    cs_on(sel);
    spi_bits(sel, 1 + aw, hdr, 1'b0, "oe_rd_hdr", rx);
    spi_bits(sel, nw * 16, 64'd0, 1'b1, "oe_rd_data", rx);
    check(tag, rx, exp_rd_q.pop_front());
    cs_off();
    check("oe_idle", 64'({miso0, oe0, miso1, oe1}), 64'd0);
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; cs0 = 1'b1; cs1 = 1'b1; mosi = 1'b0; model = '0;
    repeat (4) @(negedge clk);
    check("rst_regs0", regs0, model);
    check("rst_regs1", regs1, RST1);
    check("rst_outs0", 64'({miso0, oe0, ws0, ae0, busy0}), 64'd0);
    check("rst_wr0", 64'({wa0, wd0}), 64'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write
    wr_frame(8'h01, 16'hA5C3);
    check("t1_reg1", 64'(regs0[31:16]), 64'hA5C3);
    check("t1_busy", 64'(busy0), 64'd0);

    // Single read
    wr_frame(8'h02, 16'h1234);
    rd_frame(0, 8, 8'h02, 1, 64'h1234, "t2_rd");

    // Write burst running off the end of the register bank
    exp_wr_q.push_back({8'h02, 16'hBEEF}); model[47:32] = 16'hBEEF;
    exp_wr_q.push_back({8'h03, 16'hCAFE}); model[63:48] = 16'hCAFE;
    exp_err_q.push_back(4);
    cs_on(0);
    spi_bits(0, 57, {7'd0, 1'b0, 8'h02, 16'hBEEF, 16'hCAFE, 16'h0F0F}, 1'b0, "oe_burst", rx);
    cs_off();
    check("t3_regs", regs0, model);
    check("t3_err_drained", 64'(exp_err_q.size()), 64'd0);

    // Abort after a partial data word
    wr_frame(8'h00, 16'h5A5A);
    cs_on(0);
    spi_bits(0, 18, 64'({1'b0, 8'h00, 9'h1FF}), 1'b0, "oe_abort", rx);
    cs0 = 1'b1;
    repeat (4) @(negedge clk);
    check("t4_busy", 64'(busy0), 64'd0);
    check("t4_oe", 64'({miso0, oe0}), 64'd0);
    check("t4_regs", regs0, model);
    repeat (2 * HALF) @(negedge clk);

    // Burst read wrapping the 2-bit address
    rd_frame(1, 2, 8'h03, 2, {32'd0, 16'h4444, 16'h1111}, "t5_rd_wrap");

    // Reset in the middle of a header, then bits clocked under the same cs
    cs_on(0);
    spi_bits(0, 5, 64'h1F, 1'b0, "oe_pre_rst", rx);
    rst = 1'b1;
    model = '0;
    repeat (3) @(negedge clk);
    check("t6_rst_regs", regs0, model);
    check("t6_rst_outs", 64'({miso0, oe0, ws0, ae0, busy0}), 64'd0);
    check("t6_rst_wr", 64'({wa0, wd0}), 64'd0);
    rst = 1'b0;
    spi_bits(0, 25, 64'({1'b0, 8'h01, 16'hFFFF}), 1'b0, "oe_ignored", rx);
    repeat (HALF) @(negedge clk);
    check("t6_busy_ignored", 64'(busy0), 64'd0);
    check("t6_regs_ignored", regs0, model);
    cs_off();
    wr_frame(8'h03, 16'h7777);
    check("t6_regs_after", regs0, model);

    check("wr_q_drained", 64'(exp_wr_q.size()), 64'd0);
    check("err_q_drained", 64'(exp_err_q.size()), 64'd0);
    check("dut1_regs_end", regs1, RST1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
